keypad_scanner: RTL and testbench

- Drives the row lines of a 4x4 matrix keypad one-hot, one row at a time, and samples the column lines.
- Debounces presses and releases and presents the one-hot {row, col} pair of the pressed key, plus press/release strobes.
- Its key_row/key_col outputs feed keypad_decoder-style row/col inputs directly; active-high one-hot on both.

---
 rtl/keypad_scanner.sv | 212 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: one-hot row scanner for a 4x4 matrix keypad with debounced press/release strobes.
// Define KEYPAD_REPEAT_EN to add auto-repeat key_press pulses while a key stays held.
module keypad_scanner #(
    parameter int SETTLE_CYCLES    = 4,
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int REPEAT_DELAY     = 32,
    parameter int REPEAT_RATE      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] col_in,
    output logic [3:0] row_drive,
    output logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_down,
    output logic       key_press,
    output logic       key_release
);

    localparam int DW = $clog2(SETTLE_CYCLES);
    localparam int MW = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0] MATCH_FULL = MW'(DEBOUNCE_SAMPLES);
    localparam logic [MW-1:0] MATCH_ONE  = MW'(1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [MW-1:0] match, match_n, match_inc;
    logic [3:0]    col_meta, col_s;
    logic [3:0]    cand_row, cand_row_n;
    logic [3:0]    cand_col, cand_col_n;
    logic [3:0]    row_drive_n, row_rot;
    logic [3:0]    key_row_n, key_col_n;
    logic          key_down_n, key_press_n, key_release_n;
    logic          sample, col_valid;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_RATE);

    logic [RW-1:0] rep_cnt, rep_cnt_n, rep_inc;
    logic          rep_armed, rep_armed_n;

    assign rep_inc = rep_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_n;
            rep_armed <= rep_armed_n;
        end
    end
`endif

    // Columns are asynchronous to clk; nothing downstream looks at col_in directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '0;
            col_s    <= '0;
        end else begin
            col_meta <= col_in;
            col_s    <= col_meta;
        end
    end

    assign sample    = (dwell == DWELL_LAST);
    assign col_valid = (col_s != 4'b0000) && ((col_s & (col_s - 4'b0001)) == 4'b0000);
    assign match_inc = match + 1'b1;
    assign row_rot   = {row_drive[2:0], row_drive[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN;
            dwell       <= '0;
            match       <= '0;
            cand_row    <= '0;
            cand_col    <= '0;
            row_drive   <= 4'b0001;
            key_row     <= '0;
            key_col     <= '0;
            key_down    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_n;
            dwell       <= dwell_n;
            match       <= match_n;
            cand_row    <= cand_row_n;
            cand_col    <= cand_col_n;
            row_drive   <= row_drive_n;
            key_row     <= key_row_n;
            key_col     <= key_col_n;
            key_down    <= key_down_n;
            key_press   <= key_press_n;
            key_release <= key_release_n;
        end
    end

    // Row changes only on a sample cycle, where dwell wraps to zero anyway.
    always_comb begin
        state_n       = state;
        dwell_n       = sample ? '0 : dwell + 1'b1;
        match_n       = match;
        cand_row_n    = cand_row;
        cand_col_n    = cand_col;
        row_drive_n   = row_drive;
        key_row_n     = key_row;
        key_col_n     = key_col;
        key_down_n    = key_down;
        key_press_n   = 1'b0;
        key_release_n = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_n     = (state == HELD) ? rep_cnt : '0;
        rep_armed_n   = (state == HELD) ? rep_armed : 1'b0;
`endif

        if (!enable) begin
            state_n     = SCAN;
            dwell_n     = '0;
            match_n     = '0;
            row_drive_n = 4'b0001;
            key_down_n  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_n   = '0;
            rep_armed_n = 1'b0;
`endif
        end else if (sample) begin
            case (state)
                SCAN: begin
                    if (col_valid) begin
                        cand_row_n = row_drive;
                        cand_col_n = col_s;
                        if (DEBOUNCE_SAMPLES == 1) begin
                            key_row_n   = row_drive;
                            key_col_n   = col_s;
                            key_down_n  = 1'b1;
                            key_press_n = 1'b1;
                            match_n     = '0;
                            state_n     = HELD;
                        end else begin
                            match_n = MATCH_ONE;
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        row_drive_n = row_rot;
                    end
                end

                DEBOUNCE: begin
                    if (col_s == cand_col) begin
                        if (match_inc == MATCH_FULL) begin
                            key_row_n   = cand_row;
                            key_col_n   = cand_col;
                            key_down_n  = 1'b1;
                            key_press_n = 1'b1;
                            match_n     = '0;
                            state_n     = HELD;
                        end else begin
                            match_n = match_inc;
                        end
                    end else begin
                        match_n     = '0;
                        row_drive_n = row_rot;
                        state_n     = SCAN;
                    end
                end

                HELD: begin
                    if (col_s != key_col) begin
                        if (match_inc == MATCH_FULL) begin
                            key_down_n    = 1'b0;
                            key_release_n = 1'b1;
                            match_n       = '0;
                            row_drive_n   = row_rot;
                            state_n       = SCAN;
                        end else begin
                            match_n = match_inc;
                        end
                    end else begin
                        match_n = '0;
`ifdef KEYPAD_REPEAT_EN
                        // First repeat waits REPEAT_DELAY matching samples, later ones REPEAT_RATE.
                        if (rep_inc == (rep_armed ? REP_NEXT : REP_FIRST)) begin
                            key_press_n = 1'b1;
                            rep_cnt_n   = '0;
                            rep_armed_n = 1'b1;
                        end else begin
                            rep_cnt_n = rep_inc;
                        end
`endif
                    end
                end

                default: begin
                    match_n = '0;
                    state_n = SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives keypad_scanner through a keypad-matrix stand-in and checks it
// every cycle against a sample-level reference model plus hand-computed scenario expectations.
module tb_keypad_scanner;

    localparam int SETTLE = 4;
    localparam int DEB    = 3;
    localparam int RDELAY = 32;
    localparam int RRATE  = 8;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] keys [4];
    logic [3:0] col_in;
    logic [3:0] row_drive, key_row, key_col;
    logic       key_down, key_press, key_release;

    int checks = 0;
    int errors = 0;

    int         n_press, n_release, first_press, first_release;
    logic [3:0] rows_seen, rows_after_press, row_at_release;
    int         press_times [$];

    keypad_scanner #(
        .SETTLE_CYCLES   (SETTLE),
        .DEBOUNCE_SAMPLES(DEB),
        .REPEAT_DELAY    (RDELAY),
        .REPEAT_RATE     (RRATE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .col_in     (col_in),
        .row_drive  (row_drive),
        .key_row    (key_row),
        .key_col    (key_col),
        .key_down   (key_down),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a closed key connects its column to its row while that row is driven.
    always_comb begin
        col_in = 4'b0000;
        for (int r = 0; r < 4; r++)
            if (row_drive[r]) col_in = col_in | keys[r];
    end

    // Reference model, stepped once per clock in terms of rows, samples and agreeing-sample counts.
    logic [3:0] m_s1, m_s2, m_cand_col;
    int         m_phase, m_rowi, m_mode, m_cnt, m_cand_row, m_rep, m_rep_first;
    logic [3:0] e_key_row, e_key_col;
    logic       e_down, e_press, e_release;

    always @(posedge clk or negedge rst_n) begin : model
        logic [3:0] cs;
        bit         smp;
        bit         onehot;
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_cand_col = 0;
            m_phase = 0; m_rowi = 0; m_mode = 0; m_cnt = 0; m_cand_row = 0;
            m_rep = 0; m_rep_first = 0;
            e_key_row = 0; e_key_col = 0; e_down = 0; e_press = 0; e_release = 0;
        end else begin
            cs = m_s2;
            m_s2 = m_s1;
            m_s1 = col_in;
            e_press = 0;
            e_release = 0;
            if (!enable) begin
                m_mode = 0; m_phase = 0; m_cnt = 0; m_rowi = 0; e_down = 0;
                m_rep = 0; m_rep_first = 0;
            end else begin
                smp = (m_phase == SETTLE - 1);
                m_phase = (m_phase + 1) % SETTLE;
                onehot = ($countones(cs) == 1);
                if (smp) begin
                    if (m_mode == 0) begin
                        if (onehot) begin
                            m_cand_row = m_rowi; m_cand_col = cs; m_cnt = 1; m_mode = 1;
                        end else begin
                            m_rowi = (m_rowi + 1) % 4;
                        end
                    end else if (m_mode == 1) begin
                        if (cs == m_cand_col) m_cnt++;
                        else begin
                            m_mode = 0; m_cnt = 0; m_rowi = (m_rowi + 1) % 4;
                        end
                    end else begin
                        if (cs != e_key_col) begin
                            m_cnt++;
                            if (m_cnt >= DEB) begin
                                e_down = 0; e_release = 1; m_mode = 0; m_cnt = 0;
                                m_rowi = (m_rowi + 1) % 4;
                            end
                        end else begin
                            m_cnt = 0;
`ifdef KEYPAD_REPEAT_EN
                            m_rep++;
                            if (m_rep == (m_rep_first != 0 ? RRATE : RDELAY)) begin
                                e_press = 1; m_rep = 0; m_rep_first = 1;
                            end
`endif
                        end
                    end
                    if (m_mode == 1 && m_cnt >= DEB) begin
                        e_key_row = 4'(1 << m_cand_row);
                        e_key_col = m_cand_col;
                        e_down = 1; e_press = 1; m_mode = 2; m_cnt = 0;
                        m_rep = 0; m_rep_first = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] exp_rd;
        exp_rd = 4'(1 << m_rowi);
        checks++;
        if ({row_drive, key_row, key_col, key_down, key_press, key_release} !==
            {exp_rd, e_key_row, e_key_col, e_down, e_press, e_release}) begin
            errors++;
            $display("[TB] FAIL cycle_compare t=%0t got rd=%b kr=%b kc=%b dn=%b pr=%b rl=%b expected rd=%b kr=%b kc=%b dn=%b pr=%b rl=%b",
                     $time, row_drive, key_row, key_col, key_down, key_press, key_release,
                     exp_rd, e_key_row, e_key_col, e_down, e_press, e_release);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Set one keypad row's closed columns, then watch ncyc clocks and tally strobes.
    task automatic applyStimulus(input int row, input logic [3:0] cols, input int ncyc);
        keys[row] = cols;
        n_press = 0; n_release = 0; first_press = -1; first_release = -1;
        rows_seen = 4'b0000; rows_after_press = 4'b0000; row_at_release = 4'b0000;
        press_times.delete();
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (key_press) begin
                if (first_press < 0) first_press = k;
                n_press++;
                press_times.push_back(k);
            end
            if (key_release) begin
                if (first_release < 0) begin
                    first_release = k;
                    row_at_release = row_drive;
                end
                n_release++;
            end
            rows_seen = rows_seen | row_drive;
            if (first_press > 0) rows_after_press = rows_after_press | row_drive;
        end
    endtask

    task automatic waitRow(input logic [3:0] want);
        int n;
        n = 0;
        while (row_drive !== want && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_row", {28'd0, row_drive}, {28'd0, want});
    endtask

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [4:0] idle_other;
        int         exp_cnt;
        for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        enable = 1'b1;
        rst_n  = 1'b1;

        checkOutput("reset_row_drive", {28'd0, row_drive}, 32'h1);
        checkOutput("reset_key_row", {28'd0, key_row}, 32'h0);
        checkOutput("reset_key_col", {28'd0, key_col}, 32'h0);
        checkOutput("reset_strobes", {29'd0, key_down, key_press, key_release}, 32'h0);

        // Idle scan: row steps every SETTLE clocks.
        idle_other = 5'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            idle_other = idle_other | {|key_row, |key_col, key_down, key_press, key_release};
            if (k % 4 == 0)
                checkOutput("idle_row", {28'd0, row_drive}, 32'(1 << ((k / 4) % 4)));
        end
        checkOutput("idle_outputs_quiet", {27'd0, idle_other}, 32'h0);

        // Hold row 2 / col 1.
        applyStimulus(2, 4'b0010, 60);
        checkOutput("hold_press_count", n_press, 1);
        checkOutput("hold_press_latency_ok", {31'd0, (first_press >= 1 && first_press <= 32)}, 1);
        checkOutput("hold_key_row", {28'd0, key_row}, 32'b0100);
        checkOutput("hold_key_col", {28'd0, key_col}, 32'b0010);
        checkOutput("hold_key_down", {31'd0, key_down}, 1);
        checkOutput("hold_row_fixed", {28'd0, rows_after_press}, 32'b0100);

        // Release it.
        applyStimulus(2, 4'b0000, 20);
        checkOutput("release_count", n_release, 1);
        checkOutput("release_window_ok", {31'd0, (first_release >= 10 && first_release <= 15)}, 1);
        checkOutput("release_key_down", {31'd0, key_down}, 0);
        checkOutput("release_keeps_row", {28'd0, key_row}, 32'b0100);
        checkOutput("release_keeps_col", {28'd0, key_col}, 32'b0010);
        checkOutput("release_resume_row", {28'd0, row_at_release}, 32'b1000);
        checkOutput("release_no_press", n_press, 0);

        // Bounce: 5 clocks of contact is too short to accept.
        waitRow(4'b0100);
        applyStimulus(2, 4'b0010, 5);
        checkOutput("bounce_no_press_a", n_press, 0);
        applyStimulus(2, 4'b0000, 40);
        checkOutput("bounce_no_press_b", n_press, 0);
        checkOutput("bounce_scan_resumes", {28'd0, rows_seen}, 32'b1111);

        // Two keys on one row are ignored until one lifts.
        waitRow(4'b0100);
        applyStimulus(2, 4'b0011, 40);
        checkOutput("twokey_no_press", n_press, 0);
        checkOutput("twokey_scan_continues", {28'd0, rows_seen}, 32'b1111);
        applyStimulus(2, 4'b0001, 60);
        checkOutput("twokey_single_press", n_press, 1);
        checkOutput("twokey_key_col", {28'd0, key_col}, 32'b0001);
        checkOutput("twokey_key_row", {28'd0, key_row}, 32'b0100);

        // Drop enable while the key is down.
        checkOutput("predisable_down", {31'd0, key_down}, 1);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("disable_key_down", {31'd0, key_down}, 0);
        checkOutput("disable_row_drive", {28'd0, row_drive}, 32'b0001);
        checkOutput("disable_no_release", {31'd0, key_release}, 0);
        checkOutput("disable_keeps_row", {28'd0, key_row}, 32'b0100);
        checkOutput("disable_keeps_col", {28'd0, key_col}, 32'b0001);
        applyStimulus(2, 4'b0001, 12);
        checkOutput("disabled_no_press", n_press, 0);
        checkOutput("disabled_no_release", n_release, 0);
        checkOutput("disabled_row_parked", {28'd0, rows_seen}, 32'b0001);
        enable = 1'b1;
        applyStimulus(2, 4'b0000, 30);
        checkOutput("reenable_no_release", n_release, 0);
        checkOutput("reenable_no_press", n_press, 0);

        // Long hold: auto-repeat timing when enabled, a single press otherwise.
        waitRow(4'b0100);
        applyStimulus(2, 4'b0001, 400);
`ifdef KEYPAD_REPEAT_EN
        exp_cnt = (first_press + 128 <= 400) ? 2 + (400 - first_press - 128) / 32 : 1;
        checkOutput("repeat_press_count", n_press, exp_cnt);
        if (press_times.size() >= 3) begin
            checkOutput("repeat_first_gap", press_times[1] - press_times[0], 128);
            checkOutput("repeat_next_gap", press_times[2] - press_times[1], 32);
        end else begin
            checkOutput("repeat_press_seen", press_times.size(), 3);
        end
`else
        exp_cnt = 1;
        checkOutput("long_hold_single_press", n_press, exp_cnt);
`endif
        applyStimulus(2, 4'b0000, 20);
        checkOutput("long_release_count", n_release, 1);

        // Reset in the middle of a hold.
        applyStimulus(2, 4'b0001, 40);
        checkOutput("prereset_down", {31'd0, key_down}, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_row_drive", {28'd0, row_drive}, 32'b0001);
        checkOutput("midreset_key_row", {28'd0, key_row}, 32'h0);
        checkOutput("midreset_key_col", {28'd0, key_col}, 32'h0);
        checkOutput("midreset_strobes", {29'd0, key_down, key_press, key_release}, 32'h0);
        keys[2] = 4'b0000;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(2, 4'b0000, 8);
        checkOutput("postreset_quiet", n_press + n_release, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
